// File: rtl/bidir_ctrl_pkg.sv
// Shared types and constants for the half-duplex pad-bank turnaround controller.
// State encodings double as the DIR status code so DIR is a direct copy of the state register.
package bidir_ctrl_pkg;

  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_TX   = 2'd1;
  localparam logic [1:0] DIR_RX   = 2'd2;
  localparam logic [1:0] DIR_GAP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = DIR_IDLE,
    ST_TX   = DIR_TX,
    ST_RX   = DIR_RX,
    ST_GAP  = DIR_GAP
  } state_e;

  typedef enum logic {
    LAST_TX = 1'b0,
    LAST_RX = 1'b1
  } last_dir_e;

  function automatic bit params_ok(int width, int turn_cyc, int max_burst);
    return (width >= 1) && (width <= 32) &&
           (turn_cyc >= 1) && (turn_cyc <= 15) &&
           (max_burst >= 1) && (max_burst <= 255);
  endfunction

endpackage

// File: rtl/bidir_rr_arb.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last time.
module bidir_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic prefer_b_q, prefer_b_d;

  always_comb begin
    gnt        = req;
    prefer_b_d = prefer_b_q;
    if (req == 2'b11) begin
      gnt = prefer_b_q ? 2'b10 : 2'b01;
    end
    // After granting A, favour B next time, and vice versa.
    if (update && (gnt != 2'b00)) begin
      prefer_b_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_b_q <= 1'b0;
    end else begin
      prefer_b_q <= prefer_b_d;
    end
  end

endmodule

// File: rtl/bidir_turnaround_ctrl.sv
// Sequencer/arbiter for a shared half-duplex pad bus: two TX requesters, one RX client,
// with a programmable dead gap (both enables low) on every direction change.
module bidir_turnaround_ctrl
  import bidir_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TURN_CYC  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A_VALID,
  input  logic [WIDTH-1:0] A_DATA,
  output logic             A_READY,
  input  logic             B_VALID,
  input  logic [WIDTH-1:0] B_DATA,
  output logic             B_READY,
  input  logic             RX_REQ,
  output logic             RX_VALID,
  output logic [WIDTH-1:0] RX_DATA,
  output logic [WIDTH-1:0] O_DAT,
  output logic             O_EN,
  output logic             I_EN,
  input  logic [WIDTH-1:0] I_DAT,
  output logic [1:0]       DIR
);

  if (!params_ok(WIDTH, TURN_CYC, MAX_BURST)) begin : g_param_err
    $error("bidir_turnaround_ctrl: parameter out of range");
  end

  localparam logic [7:0] MAX_B    = 8'(MAX_BURST);
  localparam logic [3:0] GAP_LAST = 4'(TURN_CYC - 1);

  state_e           state_q, state_d;
  last_dir_e        last_dir_q, last_dir_d;
  logic             gnt_b_q, gnt_b_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [7:0]       rx_cnt_q, rx_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] o_dat_q, o_dat_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [1:0]       arb_gnt;
  logic             arb_update;
  logic             tx_any;

  assign tx_any = A_VALID | B_VALID;

  bidir_rr_arb u_arb (
    .clk    (CLK),
    .rst_n  (RST_N),
    .req    ({B_VALID, A_VALID}),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    gnt_b_d     = gnt_b_q;
    burst_cnt_d = burst_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    o_dat_d     = o_dat_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = (state_q == ST_RX);
    A_READY     = 1'b0;
    B_READY     = 1'b0;
    arb_update  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A pending RX request only blocks TX if RX did not have the bus last.
        if (tx_any && (!RX_REQ || (last_dir_q == LAST_RX))) begin
          A_READY     = arb_gnt[0];
          B_READY     = arb_gnt[1];
          arb_update  = 1'b1;
          gnt_b_d     = arb_gnt[1];
          o_dat_d     = arb_gnt[1] ? B_DATA : A_DATA;
          burst_cnt_d = 8'd1;
          last_dir_d  = LAST_TX;
          state_d     = ST_TX;
        end else if (RX_REQ) begin
          rx_cnt_d   = '0;
          last_dir_d = LAST_RX;
          state_d    = ST_RX;
        end
      end
      ST_TX: begin
        if (burst_cnt_q < MAX_B) begin
          A_READY = !gnt_b_q;
          B_READY = gnt_b_q;
        end
        if ((A_READY && A_VALID) || (B_READY && B_VALID)) begin
          o_dat_d     = gnt_b_q ? B_DATA : A_DATA;
          burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_RX: begin
        rx_data_d = I_DAT;
        if (rx_cnt_q < MAX_B) begin
          rx_cnt_d = rx_cnt_q + 8'd1;
        end
        if (!RX_REQ || (tx_any && (rx_cnt_q == MAX_B))) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      last_dir_q  <= LAST_RX;
      gnt_b_q     <= 1'b0;
      burst_cnt_q <= '0;
      rx_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      o_dat_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      gnt_b_q     <= gnt_b_d;
      burst_cnt_q <= burst_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      o_dat_q     <= o_dat_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  // Enables decode straight from the state flop so reset drops them without a clock.
  assign O_EN     = (state_q == ST_TX);
  assign I_EN     = (state_q == ST_RX);
  assign DIR      = state_q;
  assign O_DAT    = o_dat_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;

endmodule

// File: tb/tb_bidir_turnaround_ctrl.sv
// Directed bench for bidir_turnaround_ctrl (WIDTH=8, TURN_CYC=2, MAX_BURST=4).
module tb_bidir_turnaround_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       A_VALID, B_VALID, RX_REQ;
  logic [7:0] A_DATA, B_DATA, I_DAT;
  logic       A_READY, B_READY, RX_VALID, O_EN, I_EN;
  logic [7:0] RX_DATA, O_DAT;
  logic [1:0] DIR;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_dat, a_cnt, b_cnt;
  bit          is_b;

  bidir_turnaround_ctrl #(
    .WIDTH     (8),
    .TURN_CYC  (2),
    .MAX_BURST (4)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .A_VALID  (A_VALID),
    .A_DATA   (A_DATA),
    .A_READY  (A_READY),
    .B_VALID  (B_VALID),
    .B_DATA   (B_DATA),
    .B_READY  (B_READY),
    .RX_REQ   (RX_REQ),
    .RX_VALID (RX_VALID),
    .RX_DATA  (RX_DATA),
    .O_DAT    (O_DAT),
    .O_EN     (O_EN),
    .I_EN     (I_EN),
    .I_DAT    (I_DAT),
    .DIR      (DIR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N   = 1'b0;
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    RX_REQ  = 1'b0;
    A_DATA  = '0;
    B_DATA  = '0;
    I_DAT   = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (RST_N && O_EN && I_EN) check_eq("enables_exclusive", {O_EN, I_EN}, 2'b00);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    #1;
    check_eq("rst_dir", DIR, 2'd0);
    check_eq("rst_en", {O_EN, I_EN}, 2'b00);
    check_eq("rst_odat", O_DAT, 8'h00);
    check_eq("rst_rx", {RX_VALID, RX_DATA}, 9'h000);
    check_eq("rst_ready", {A_READY, B_READY}, 2'b00);

    // Three-word burst from A
    A_VALID = 1'b1; A_DATA = 8'h11;
    #1;
    check_eq("t1_idle_ready", A_READY, 1'b1);
    check_eq("t1_idle_oen", O_EN, 1'b0);
    next_cycle();
    A_DATA = 8'h22;
    #1;
    check_eq("t1_odat11", {O_EN, O_DAT}, 9'h111);
    check_eq("t1_ready2", A_READY, 1'b1);
    next_cycle();
    A_DATA = 8'h33;
    #1;
    check_eq("t1_odat22", {O_EN, O_DAT}, 9'h122);
    check_eq("t1_ready3", A_READY, 1'b1);
    next_cycle();
    A_VALID = 1'b0;
    #1;
    check_eq("t1_odat33", {O_EN, O_DAT}, 9'h133);
    check_eq("t1_dir_tx", DIR, 2'd1);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("t1_gap", {O_EN, I_EN, DIR}, 4'b0011);
      next_cycle();
    end
    #1;
    check_eq("t1_idle_after", DIR, 2'd0);
    check_eq("t1_odat_hold", O_DAT, 8'h33);

    // Round-robin with both requesters continuously valid
    do_reset();
    A_VALID = 1'b1; B_VALID = 1'b1;
    a_cnt = '0; b_cnt = '0; exp_dat = '0;
    for (int g = 0; g < 3; g++) begin
      is_b = (g == 1);
      for (int h = 0; h < 4; h++) begin
        A_DATA = 8'hA0 + a_cnt;
        B_DATA = 8'hB0 + b_cnt;
        #1;
        check_eq("rr_a_ready", A_READY, !is_b);
        check_eq("rr_b_ready", B_READY, is_b);
        if (h == 0) check_eq("rr_idle_dead", {O_EN, I_EN, DIR}, 4'b0000);
        else        check_eq("rr_odat", {O_EN, O_DAT}, {1'b1, exp_dat});
        exp_dat = is_b ? B_DATA : A_DATA;
        if (is_b) b_cnt++;
        else      a_cnt++;
        next_cycle();
      end
      #1;
      check_eq("rr_last_drive", {O_EN, O_DAT}, {1'b1, exp_dat});
      check_eq("rr_exhausted", {A_READY, B_READY}, 2'b00);
      next_cycle();
      for (int k = 0; k < 2; k++) begin
        #1;
        check_eq("rr_gap", {O_EN, I_EN, DIR}, 4'b0011);
        check_eq("rr_gap_ready", {A_READY, B_READY}, 2'b00);
        next_cycle();
      end
    end

    // Basic receive
    do_reset();
    RX_REQ = 1'b1; I_DAT = 8'hA5;
    #1;
    check_eq("rx_idle", {I_EN, DIR}, 3'b000);
    next_cycle();
    #1;
    check_eq("rx_ien", {I_EN, DIR}, 3'b110);
    check_eq("rx_valid0", RX_VALID, 1'b0);
    next_cycle();
    I_DAT = 8'h3C; RX_REQ = 1'b0;
    #1;
    check_eq("rx_data_a5", {RX_VALID, RX_DATA}, 9'h1A5);
    check_eq("rx_ien2", I_EN, 1'b1);
    next_cycle();
    #1;
    check_eq("rx_ien_drop", {I_EN, DIR}, 3'b011);
    check_eq("rx_data_3c", {RX_VALID, RX_DATA}, 9'h13C);
    next_cycle();
    #1;
    check_eq("rx_valid_drop", RX_VALID, 1'b0);

    // TX waits for MAX_BURST RX cycles, then the turnaround gap
    do_reset();
    RX_REQ = 1'b1; I_DAT = 8'h10;
    #1;
    next_cycle();
    #1;
    check_eq("pre_r0", I_EN, 1'b1);
    next_cycle();
    A_VALID = 1'b1; A_DATA = 8'h5A;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check_eq("pre_rx_hold", {O_EN, I_EN}, 2'b01);
      check_eq("pre_no_ready", A_READY, 1'b0);
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("pre_dead", {O_EN, I_EN}, 2'b00);
      if (k < 2) check_eq("pre_gap_dir", DIR, 2'd3);
      else       check_eq("pre_idle_ready", {DIR, A_READY}, 3'b001);
      next_cycle();
    end
    A_VALID = 1'b0; RX_REQ = 1'b0;
    #1;
    check_eq("pre_tx", {O_EN, DIR, O_DAT}, {1'b1, 2'd1, 8'h5A});
    next_cycle();
    #1;
    check_eq("pre_tx_gap", DIR, 2'd3);

    // Simultaneous RX_REQ and A_VALID from reset
    do_reset();
    RX_REQ = 1'b1; A_VALID = 1'b1; A_DATA = 8'h77;
    #1;
    check_eq("sim_tx_wins", A_READY, 1'b1);
    next_cycle();
    A_VALID = 1'b0;
    #1;
    check_eq("sim_tx", {DIR, O_DAT}, {2'd1, 8'h77});
    next_cycle();
    A_VALID = 1'b1; A_DATA = 8'h88;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("sim_gap", {DIR, A_READY}, 3'b110);
      next_cycle();
    end
    #1;
    check_eq("sim_idle_rx_wins", {DIR, A_READY}, 3'b000);
    next_cycle();
    #1;
    check_eq("sim_rx", {DIR, I_EN, O_EN}, 4'b1010);

    // Asynchronous reset during TX
    do_reset();
    A_VALID = 1'b1; A_DATA = 8'hC3;
    #1;
    next_cycle();
    #1;
    check_eq("ar_tx", {O_EN, O_DAT}, 9'h1C3);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("ar_oen_drop", O_EN, 1'b0);
    check_eq("ar_dir", DIR, 2'd0);
    A_VALID = 1'b0;
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    #1;
    check_eq("ar_after_state", {DIR, O_EN, I_EN}, 4'b0000);
    check_eq("ar_after_odat", O_DAT, 8'h00);
    check_eq("ar_after_ready", {A_READY, B_READY}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
